// File: rtl/peri_timer_pkg.sv
// peri_timer_pkg: shared timer register map, TCON bit positions and register selector
package peri_timer_pkg;
  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_PEND = 2;
  typedef enum logic [1:0] {REG_TH, REG_TL, REG_TCON, REG_PSC} regSel_e;
endpackage

// File: rtl/peri_prescaler.sv
// peri_prescaler: divides enabled cycles by psc+1 and emits a one-cycle tick
module peri_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);
  logic [PSC_W-1:0] cnt;
  assign tick = en && cnt == psc;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/peri_timer.sv
// peri_timer: memory-mapped reload timer with prescaler and overflow interrupt
module peri_timer
  import peri_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int          PSC_W     = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oAccessable,
  output logic        oIrq
);
  logic [31:0] th, tl, rdSel;
  logic [PSC_W-1:0] psc;
  logic en, ie, pend, tick, hit, wrTh, wrTl, wrTcon, wrPsc, overflow;
  regSel_e sel;
  assign hit = iAddr[31:4] == BASE_ADDR[31:4] && iAddr[1:0] == 2'b00;
  assign sel = regSel_e'(iAddr[3:2]);
  assign oAccessable = hit;
  assign wrTh = iWr && hit && sel == REG_TH;
  assign wrTl = iWr && hit && sel == REG_TL;
  assign wrTcon = iWr && hit && sel == REG_TCON;
  assign wrPsc = iWr && hit && sel == REG_PSC;
  // a bus write to TL overrides the tick, so it can never flag an overflow
  assign overflow = tick && !wrTl && tl == 32'hFFFF_FFFF;
  assign oIrq = pend & ie;
  peri_prescaler #(.PSC_W(PSC_W)) uPrescaler (
    .clk(iClk), .rst(iRst), .en(en), .clr(wrPsc), .psc(psc), .tick(tick)
  );
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      th <= '0;
      tl <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      pend <= 1'b0;
      psc <= '0;
    end else begin
      if (wrTh) th <= iWrData;
      if (wrTl) tl <= iWrData;
      else if (tick) tl <= tl == 32'hFFFF_FFFF ? th : tl + 1'b1;
      if (wrTcon) begin
        en <= iWrData[TCON_EN];
        ie <= iWrData[TCON_IE];
      end
      pend <= overflow | (pend & !(wrTcon && iWrData[TCON_PEND]));
      if (wrPsc) psc <= iWrData[PSC_W-1:0];
    end
  always_comb begin
    rdSel = sel == REG_TH   ? th :
            sel == REG_TL   ? tl :
            sel == REG_TCON ? {29'b0, pend, ie, en} : 32'(psc);
    oRdData = (iRd && hit) ? rdSel : '0;
  end
endmodule

// File: tb/tb_peri_timer.sv
// tb_peri_timer: directed stimulus with a cycle-level behavioural model and literal checks
module tb_peri_timer;
  localparam logic [31:0] B = 32'h4000_0000;
  logic iClk, iRst, iRd, iWr, oAccessable, oIrq;
  logic [31:0] iAddr, iWrData, oRdData;
  int nTests = 0, nFail = 0;
  bit run = 0;

  peri_timer dut (
    .iClk(iClk), .iRst(iRst), .iRd(iRd), .iWr(iWr), .iAddr(iAddr),
    .iWrData(iWrData), .oRdData(oRdData), .oAccessable(oAccessable), .oIrq(oIrq)
  );

  initial iClk = 0;
  always #5 iClk = ~iClk;

  // model: registers plus a count of enabled cycles since the prescaler phase restarted
  logic [31:0] mTh, mTl, nTh, nTl, expReg;
  logic [7:0] mPsc, nPsc;
  logic mEn, mIe, mPend, nEn, nIe, nPend, mHit, mTick, mOvf;
  int unsigned mElapsed, nElapsed;

  function automatic logic decode(input logic [31:0] a);
    return a[31:4] == B[31:4] && a[1:0] == 2'b00;
  endfunction

  always_comb begin
    mHit = decode(iAddr);
    mTick = mEn && ((mElapsed + 1) % (int'(mPsc) + 1) == 0);
    mOvf = mTick && mTl == 32'hFFFF_FFFF && !(iWr && mHit && iAddr[3:2] == 2'd1);
    nTh = mTh;
    nTl = !mTick ? mTl : (mTl == 32'hFFFF_FFFF ? mTh : mTl + 1);
    nEn = mEn;
    nIe = mIe;
    nPsc = mPsc;
    nPend = mPend | mOvf;
    nElapsed = mEn ? mElapsed + 1 : 0;
    if (iWr && mHit)
      case (iAddr[3:2])
        2'd0: nTh = iWrData;
        2'd1: nTl = iWrData;
        2'd2: begin
          nEn = iWrData[0];
          nIe = iWrData[1];
          nPend = mOvf | (mPend & !iWrData[2]);
        end
        default: begin
          nPsc = iWrData[7:0];
          nElapsed = 0;
        end
      endcase
    case (iAddr[3:2])
      2'd0: expReg = mTh;
      2'd1: expReg = mTl;
      2'd2: expReg = {29'b0, mPend, mIe, mEn};
      default: expReg = {24'b0, mPsc};
    endcase
  end

  always @(posedge iClk or posedge iRst)
    if (iRst) begin
      mTh <= 0; mTl <= 0; mEn <= 0; mIe <= 0; mPend <= 0; mPsc <= 0; mElapsed <= 0;
    end else begin
      mTh <= nTh; mTl <= nTl; mEn <= nEn; mIe <= nIe; mPend <= nPend; mPsc <= nPsc;
      mElapsed <= nElapsed;
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iClk)
    if (run && !iRst) begin
      check("model_acc", 32'(oAccessable), 32'(mHit));
      check("model_rdata", oRdData, (iRd && mHit) ? expReg : 32'h0);
      check("model_irq", 32'(oIrq), 32'(mPend & mIe));
    end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iRd = 0; iWr = 1; iAddr = a; iWrData = d;
    @(posedge iClk); #1;
    iWr = 0;
  endtask

  task automatic idle(input int n);
    iRd = 1; iAddr = B + 4;
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    iRd = 1; iAddr = a;
    #3 check(name, oRdData, exp);
    iRd = 0;
  endtask

  task automatic chkAcc(input string name, input logic [31:0] a, input logic expAcc);
    iRd = 1; iAddr = a;
    #3 check({name, "_acc"}, 32'(oAccessable), 32'(expAcc));
    check({name, "_rd"}, oRdData, expAcc ? oRdData : 32'h0);
    iRd = 0;
  endtask

  initial begin
    iRst = 1; iRd = 0; iWr = 0; iAddr = 0; iWrData = 0;
    repeat (2) @(posedge iClk);
    #1 iRst = 0;
    run = 1;
    chk("rst_tcon", B + 8, 32'h0);
    // reset mid-count
    wr(B + 12, 0); wr(B + 4, 32'h100); wr(B + 8, 1);
    idle(3);
    chk("count_pre_rst", B + 4, 32'h103);
    iRst = 1;
    chk("rst_tl", B + 4, 32'h0);
    chk("rst_tcon_mid", B + 8, 32'h0);
    check("rst_irq", 32'(oIrq), 32'h0);
    @(posedge iClk); #1 iRst = 0;
    idle(3);
    chk("frozen_tl", B + 4, 32'h0);
    chk("frozen_tcon", B + 8, 32'h0);
    // overflow and reload
    wr(B, 32'hFFFF_FFF0); wr(B + 4, 32'hFFFF_FFFE); wr(B + 12, 0); wr(B + 8, 3);
    chk("ovf_tl0", B + 4, 32'hFFFF_FFFE);
    idle(1);
    chk("ovf_tl1", B + 4, 32'hFFFF_FFFF);
    chk("ovf_tcon1", B + 8, 32'h3);
    idle(1);
    chk("ovf_reload", B + 4, 32'hFFFF_FFF0);
    chk("ovf_tcon2", B + 8, 32'h7);
    check("ovf_irq", 32'(oIrq), 32'h1);
    idle(1);
    chk("ovf_after", B + 4, 32'hFFFF_FFF1);
    // W1C
    wr(B + 8, 6);
    chk("w1c_tcon", B + 8, 32'h2);
    check("w1c_irq", 32'(oIrq), 32'h0);
    chk("w1c_last_tick", B + 4, 32'hFFFF_FFF2);
    wr(B + 4, 32'hFFFF_FFFF); wr(B + 8, 3);
    idle(1);
    wr(B + 8, 2);
    chk("w0_tcon", B + 8, 32'h6);
    check("w0_irq", 32'(oIrq), 32'h1);
    chk("w0_tl", B + 4, 32'hFFFF_FFF1);
    // prescaler
    wr(B + 8, 6); wr(B + 12, 3); wr(B + 4, 0); wr(B + 8, 1);
    idle(12);
    chk("psc_tl3", B + 4, 32'h3);
    idle(2);
    wr(B + 12, 3);
    idle(3);
    chk("psc_restart", B + 4, 32'h3);
    idle(1);
    chk("psc_tick", B + 4, 32'h4);
    // collisions
    wr(B + 12, 0);
    wr(B + 4, 32'h55);
    chk("col_tlwr", B + 4, 32'h55);
    wr(B + 4, 32'hFFFF_FFFF); wr(B + 4, 32'h10);
    chk("col_tlwr_ovf", B + 4, 32'h10);
    chk("col_no_pend", B + 8, 32'h1);
    wr(B + 4, 32'hFFFF_FFFF); wr(B + 8, 5);
    chk("col_w1c", B + 8, 32'h5);
    check("col_masked_irq", 32'(oIrq), 32'h0);
    chk("col_w1c_tl", B + 4, 32'hFFFF_FFF0);
    wr(B + 4, 32'hFFFF_FFFF); wr(B, 32'h200);
    chk("col_th_old", B + 4, 32'hFFFF_FFF0);
    chk("col_th_new", B, 32'h200);
    wr(B + 8, 4);
    chk("col_stop", B + 8, 32'h0);
    // decode
    wr(B + 12, 32'hFFFF_FFA5);
    chk("dec_psc", B + 12, 32'h0000_00A5);
    wr(B + 6, 32'h1234); wr(B + 32'h14, 1); wr(32'h3000_0004, 9);
    chk("dec_tl", B + 4, 32'hFFFF_FFF1);
    chk("dec_th", B, 32'h200);
    chkAcc("dec_0x10", B + 32'h10, 1'b0);
    chkAcc("dec_0x02", B + 2, 1'b0);
    chkAcc("dec_0x08", B + 8, 1'b1);
    // simultaneous read and write
    iRd = 1; iWr = 1; iAddr = B; iWrData = 32'h77;
    #3 check("rdwr_old", oRdData, 32'h200);
    @(posedge iClk); #1 iWr = 0;
    #3 check("rdwr_new", oRdData, 32'h77);
    iRd = 0;
    idle(2);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
